// File: rtl/ad9914_pkg.sv
// ad9914_pkg: register map indices and DRG state encoding shared by the AD9914 port model.
package ad9914_pkg;

  localparam int CFR1      = 0;
  localparam int CFR2      = 1;
  localparam int CFR3      = 2;
  localparam int CFR4      = 3;
  localparam int DRG_LOWER = 4;
  localparam int DRG_UPPER = 5;
  localparam int DRG_RSTEP = 6;
  localparam int DRG_FSTEP = 7;
  localparam int DRG_RATE  = 8;
  localparam int PROFILE0  = 12;

  localparam int CFR2_DRG_EN = 19;

  typedef enum logic [1:0] {
    DRG_IDLE,
    DRG_WAIT,
    DRG_STEP,
    DRG_DONE
  } drg_state_e;

endpackage

// File: rtl/ad9914_drg_model.sv
// ad9914_drg_model: rising-ramp accumulator of the AD9914 digital ramp generator.
// state | meaning: IDLE no ramp | WAIT rate countdown | STEP add step, test limit | DONE at upper, dover high
module ad9914_drg_model
  import ad9914_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        start,
  input  logic        hold,
  input  logic [31:0] lower,
  input  logic [31:0] upper,
  input  logic [31:0] step,
  input  logic [15:0] rate,
  output logic [31:0] acc,
  output logic        dover
);

  drg_state_e  state;
  logic [15:0] cnt;
  logic [32:0] sum;

  assign sum = {1'b0, acc} + {1'b0, step};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DRG_IDLE;
      acc   <= '0;
      cnt   <= '0;
      dover <= 1'b0;
    end else if (clr || !en) begin
      state <= DRG_IDLE;
      acc   <= '0;
      cnt   <= '0;
      dover <= 1'b0;
    end else if (start) begin
      state <= DRG_WAIT;
      acc   <= lower;
      cnt   <= rate;
      dover <= 1'b0;
    end else if (!hold) begin
      case (state)
        // a rate of 0 or 1 both give the fastest cadence of one step every two clocks
        DRG_WAIT: begin
          if (cnt <= 16'd1) begin
            cnt   <= '0;
            state <= DRG_STEP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DRG_STEP: begin
          if (sum[32] || (sum[31:0] >= upper)) begin
            acc   <= upper;
            dover <= 1'b1;
            state <= DRG_DONE;
          end else begin
            acc   <= sum[31:0];
            cnt   <= rate;
            state <= DRG_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ad9914_port_model.sv
// ad9914_port_model: device-side responder for the AD9914 8-bit parallel port (shadow/active registers).
// Define AD9914_MODEL_DRG_EN to include the digital ramp generator model.
module ad9914_port_model
  import ad9914_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_pwd,
  input  logic        p_wr_n,
  input  logic        p_rd_n,
  input  logic [7:0]  p_addr,
  input  logic [7:0]  p_data_in,
  output logic [7:0]  p_data_out,
  output logic        p_data_oe,
  input  logic        io_update,
  input  logic        master_reset,
  input  logic        dctrl,
  input  logic        dhold,
  output logic        dover,
  output logic [31:0] ramp_acc,
  output logic        proto_err
);

  localparam int IN_W = 23;
  // strobes sit at their inactive (high) level out of reset so no phantom access is seen
  localparam logic [IN_W-1:0] IN_IDLE = 23'h300000;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] ADDR_LIM = 9'(4 * NUM_REGS);

  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic            pwd_s, wr_s, rd_s, io_s, mrst_s, dctrl_s, dhold_s;
  logic [7:0]      addr_s, data_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IN_IDLE;
    end else begin
      sync_q[0] <= {p_pwd, p_wr_n, p_rd_n, p_addr, p_data_in, io_update, master_reset, dctrl, dhold};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {pwd_s, wr_s, rd_s, addr_s, data_s, io_s, mrst_s, dctrl_s, dhold_s} = sync_q[SYNC_STAGES-1];

  logic [31:0]      shadow [NUM_REGS];
  logic [31:0]      active [NUM_REGS];
  logic             wr_prev, io_prev, wr_bad;
  logic             wr_rise, io_rise, addr_ok;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rd_byte;

  assign wr_rise = wr_s & ~wr_prev;
  assign io_rise = io_s & ~io_prev;
  assign addr_ok = {1'b0, addr_s} < ADDR_LIM;
  assign idx     = addr_s[IDX_W+1:2];
  assign rd_byte = addr_ok ? active[idx][{addr_s[1:0], 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      wr_prev    <= 1'b1;
      io_prev    <= 1'b0;
      wr_bad     <= 1'b0;
      p_data_out <= '0;
      p_data_oe  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      wr_prev <= wr_s;
      io_prev <= io_s;
      if (pwd_s) proto_err <= 1'b1;
      if (mrst_s) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          shadow[i] <= '0;
          active[i] <= '0;
        end
        wr_bad     <= 1'b0;
        p_data_out <= '0;
        p_data_oe  <= 1'b0;
      end else begin
        // a write strobe that overlapped a read is poisoned until its rising edge
        if (!wr_s && !rd_s) begin
          proto_err <= 1'b1;
          wr_bad    <= 1'b1;
        end
        if (io_rise) begin
          for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
        end
        if (wr_rise) begin
          if (!wr_bad && addr_ok) shadow[idx][{addr_s[1:0], 3'b000} +: 8] <= data_s;
          wr_bad <= 1'b0;
        end
        p_data_oe  <= ~rd_s;
        p_data_out <= rd_s ? 8'h00 : rd_byte;
      end
    end
  end

`ifdef AD9914_MODEL_DRG_EN
  logic dctrl_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dctrl_prev <= 1'b0;
    else      dctrl_prev <= dctrl_s;
  end

  ad9914_drg_model u_drg (
    .clk   (clk),
    .rst   (rst),
    .clr   (mrst_s),
    .en    (active[CFR2][CFR2_DRG_EN]),
    .start (dctrl_s & ~dctrl_prev),
    .hold  (dhold_s),
    .lower (active[DRG_LOWER]),
    .upper (active[DRG_UPPER]),
    .step  (active[DRG_RSTEP]),
    .rate  (active[DRG_RATE][15:0]),
    .acc   (ramp_acc),
    .dover (dover)
  );
`else
  logic unused_ramp;
  assign unused_ramp = dctrl_s ^ dhold_s;
  assign dover       = 1'b0;
  assign ramp_acc    = '0;
`endif

endmodule
